// File: rtl/cfg_serial_loader.sv
// Serial configuration loader: shifts a dynamic chain (SEL=1) and then a static
// chain (SEL=0) out on MOSI/SCLK, with SCLK derived from CLK by a programmable divider.
module cfg_serial_loader #(
  parameter int                DYN_W     = 16,
  parameter int                STAT_W    = 88,
  parameter logic [DYN_W-1:0]  DYN_INIT  = 16'hABC6,
  parameter logic [STAT_W-1:0] STAT_INIT = 88'h123456789ABCDEF1234567,
  parameter int                CLK_DIV   = 8,
  parameter int                IDLE_WAIT = 60,
  parameter int                GAP_CYC   = 4,
  parameter bit                LSB_FIRST = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              abort,
  input  logic              use_default,
  input  logic [DYN_W-1:0]  dyn_data,
  input  logic [STAT_W-1:0] stat_data,
  output logic              SCLK,
  output logic              SEL,
  output logic              MOSI,
  output logic              busy,
  output logic              done
);

  localparam int MAX_W  = (DYN_W > STAT_W) ? DYN_W : STAT_W;
  localparam int BIT_CW = $clog2(MAX_W);
  localparam int DIV_CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GRD_CW = (IDLE_WAIT > 0) ? $clog2(IDLE_WAIT + 1) : 1;

  localparam logic [DIV_CW-1:0] DIV_LAST  = DIV_CW'(CLK_DIV - 1);
  localparam logic [GAP_CW-1:0] GAP_LAST  = GAP_CW'(GAP_CYC - 1);
  localparam logic [GRD_CW-1:0] GRD_MAX   = GRD_CW'(IDLE_WAIT);
  localparam logic [BIT_CW-1:0] DYN_LAST  = BIT_CW'(DYN_W - 1);
  localparam logic [BIT_CW-1:0] STAT_LAST = BIT_CW'(STAT_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_DYN, S_GAP, S_STAT, S_DONE} state_t;

  // The bit on the wire is always the head of the shift register.
  function automatic logic dyn_head(input logic [DYN_W-1:0] v);
    return LSB_FIRST ? v[0] : v[DYN_W-1];
  endfunction

  function automatic logic [DYN_W-1:0] dyn_shift(input logic [DYN_W-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic stat_head(input logic [STAT_W-1:0] v);
    return LSB_FIRST ? v[0] : v[STAT_W-1];
  endfunction

  function automatic logic [STAT_W-1:0] stat_shift(input logic [STAT_W-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  state_t              r_state, w_state;
  logic [GRD_CW-1:0]   r_guard, w_guard;
  logic [DIV_CW-1:0]   r_div, w_div;
  logic                r_ph, w_ph;
  logic [BIT_CW-1:0]   r_bit, w_bit;
  logic [GAP_CW-1:0]   r_gap, w_gap;
  logic [DYN_W-1:0]    r_dyn_sr, w_dyn_sr;
  logic [STAT_W-1:0]   r_stat_sr, w_stat_sr;
  logic                r_sclk, w_sclk;
  logic                r_sel, w_sel;
  logic                r_mosi, w_mosi;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                w_launch;
  logic                w_bit_end;

  always_comb begin
    w_state   = r_state;
    w_guard   = r_guard;
    w_div     = r_div;
    w_ph      = r_ph;
    w_bit     = r_bit;
    w_gap     = r_gap;
    w_dyn_sr  = r_dyn_sr;
    w_stat_sr = r_stat_sr;
    w_launch  = 1'b0;
    w_bit_end = (r_div == DIV_LAST) && r_ph;

    if (r_state == S_IDLE && r_guard != GRD_MAX)
      w_guard = r_guard + 1'b1;

    if (abort) begin
      w_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start && r_guard == GRD_MAX) w_launch = 1'b1;
        S_DONE: if (start) w_launch = 1'b1;
        S_DYN, S_STAT: begin
          w_div = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
          if (r_div == DIV_LAST) w_ph = ~r_ph;
          if (w_bit_end) begin
            if (r_bit == ((r_state == S_DYN) ? DYN_LAST : STAT_LAST)) begin
              w_bit   = '0;
              w_state = (r_state == S_DYN) ? S_GAP : S_DONE;
            end else begin
              w_bit = r_bit + 1'b1;
              if (r_state == S_DYN) w_dyn_sr  = dyn_shift(r_dyn_sr);
              else                  w_stat_sr = stat_shift(r_stat_sr);
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            w_gap   = '0;
            w_state = S_STAT;
          end else begin
            w_gap = r_gap + 1'b1;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end

    // Launch restarts every counter, since an abort may have left them mid-bit.
    if (w_launch) begin
      w_state   = S_DYN;
      w_div     = '0;
      w_ph      = 1'b0;
      w_bit     = '0;
      w_gap     = '0;
      w_dyn_sr  = use_default ? DYN_INIT  : dyn_data;
      w_stat_sr = use_default ? STAT_INIT : stat_data;
    end

    // Outputs are decoded from the next state so they register in step with it.
    w_sel  = (w_state == S_DYN);
    w_sclk = ((w_state == S_DYN) || (w_state == S_STAT)) && w_ph;
    w_mosi = 1'b0;
    if (w_state == S_DYN)       w_mosi = dyn_head(w_dyn_sr);
    else if (w_state == S_STAT) w_mosi = stat_head(w_stat_sr);
    w_busy = (w_state == S_DYN) || (w_state == S_GAP) || (w_state == S_STAT);
    w_done = (w_state == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_guard   <= '0;
      r_div     <= '0;
      r_ph      <= 1'b0;
      r_bit     <= '0;
      r_gap     <= '0;
      r_dyn_sr  <= DYN_INIT;
      r_stat_sr <= STAT_INIT;
      r_sclk    <= 1'b0;
      r_sel     <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_guard   <= w_guard;
      r_div     <= w_div;
      r_ph      <= w_ph;
      r_bit     <= w_bit;
      r_gap     <= w_gap;
      r_dyn_sr  <= w_dyn_sr;
      r_stat_sr <= w_stat_sr;
      r_sclk    <= w_sclk;
      r_sel     <= w_sel;
      r_mosi    <= w_mosi;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign SCLK = r_sclk;
  assign SEL  = r_sel;
  assign MOSI = r_mosi;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/cfg_serial_loader.md
Name: cfg_serial_loader

Overview:
- Parametrised successor to the fixed-width 2 MHz DYNCNF/STATCNF sender.
- Shifts a dynamic and a static configuration word into the ASIC analog part over SEL/MOSI/SCLK.
- Runs entirely on one system clock, with SCLK generated internally by a programmable divider.
- Adds runtime-loadable data, LSB/MSB-first order, inter-chain gap, start/busy/done handshake, abort and relaunch.

Parameters:
- DYN_W, 16, dynamic chain length in bits (>=2)
- STAT_W, 88, static chain length in bits (>=2)
- DYN_INIT, 16'hABC6, default dynamic word (DYN_W bits)
- STAT_INIT, 88'h123456789ABCDEF1234567, default static word (STAT_W bits)
- CLK_DIV, 8, SCLK half-period in CLK cycles (>=1); one bit = 2*CLK_DIV cycles
- IDLE_WAIT, 60, CLK cycles after reset before start is honoured
- GAP_CYC, 4, CLK cycles between chains with SEL=0 and SCLK=0 (>=1)
- LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB shifted first

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous active-low reset
- start  in  1  launch request, sampled each CLK
- abort  in  1  cancel transfer, return to IDLE
- use_default  in  1  at launch: 1 = load DYN_INIT/STAT_INIT, 0 = load ports
- dyn_data  in  DYN_W  dynamic word, sampled at launch only
- stat_data  in  STAT_W  static word, sampled at launch only
- SCLK  out  1  serial bit clock, gated, 0 when not shifting
- SEL  out  1  1 during dynamic chain, 0 otherwise
- MOSI  out  1  serial data
- busy  out  1  1 from launch until DONE is entered
- done  out  1  1 in DONE state

Behaviour:
- Reset (RST_N=0 at a CLK edge): all outputs 0. State IDLE, guard counter 0, shift regs = INIT values. Applies mid-transfer with no completion.
- All outputs are registered.
- States: IDLE, DYN, GAP, STAT, DONE.
- IDLE: the guard counter increments to IDLE_WAIT and saturates.
  - start honoured only when guard == IDLE_WAIT; earlier start pulses are dropped, not queued.
  - Launch edge: latch both shift regs (INIT or ports per use_default); next cycle enter DYN with busy=1.
- Bit timing (DYN and STAT):
  - Each bit spans 2*CLK_DIV cycles: first CLK_DIV cycles SCLK=0, last CLK_DIV cycles SCLK=1.
  - MOSI updates on the first cycle of each bit, so the slave samples on the SCLK rising edge.
  - Bit order follows LSB_FIRST; the shift reg shifts by one per bit.
- DYN: SEL=1 for exactly DYN_W*2*CLK_DIV cycles, then GAP.
- GAP: SEL=0, SCLK=0, MOSI=0 for GAP_CYC cycles, then STAT.
- STAT: SEL=0 for STAT_W*2*CLK_DIV cycles, then DONE.
- DONE: SCLK=SEL=MOSI=0, busy=0, done=1, held indefinitely.
  - start in DONE relaunches immediately (guard stays satisfied) and clears done on the next cycle.
- start while in DYN, GAP or STAT is ignored. Input data changes after launch have no effect.
- abort=1 in any state:
  - Next cycle IDLE, SCLK=SEL=MOSI=busy=done=0; the guard stays saturated.
  - abort wins over a simultaneous start.
- Counters are sized with $clog2 of their maximum, with no wrap in any legal configuration.
- Bit counter terminal value: W-1 on the last half-period edge.

Test Plan:
- Bench params: DYN_W=4, STAT_W=8, CLK_DIV=2, IDLE_WAIT=5, GAP_CYC=3, LSB_FIRST=0.
- Guard: start held high from reset release → no launch before cycle 5; launch at cycle 5; SEL rises at cycle 6.
- Full frame: use_default=0, dyn_data=4'hA, stat_data=8'hC5:
  - SEL=1 for 16 cycles, MOSI 1,0,1,0.
  - 3-cycle gap.
  - 32 cycles of MOSI 1,1,0,0,0,1,0,1.
  - 8 SCLK rising edges in STAT.
  - done=1 at cycle 51 after DYN entry; busy low the same cycle.
- LSB_FIRST=1, dyn_data=4'h1: MOSI sequence 1,0,0,0.
- use_default=1 → MOSI streams reproduce DYN_INIT then STAT_INIT exactly.
- Abort at the 3rd STAT bit with start also high → next cycle IDLE, all outputs 0, no done. A later start relaunches with no guard wait.
- RST_N low for 1 cycle mid-DYN → all outputs 0 next edge. Start is ignored for 5 cycles, then a frame completes normally.
- Relaunch from DONE with new stat_data=8'h3C → done clears and the second frame shifts 0,0,1,1,1,1,0,0.
